// File: rtl/nibble_serial_add_seq.sv
`timescale 1ns/1ps
// nibble_serial_add_seq
// Feeds wide operands, one nibble per cycle with the least significant nibble
// first, to an external combinational 4-bit ripple-carry adder. The block keeps
// the carry between nibbles in a register and assembles the sum nibbles into
// the wide result, so one small adder can serve a wide add or subtract.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | In_ready=1, waiting for In_valid to latch the operands
//   RUN     | one nibble per cycle through the external adder, k = 0..N-1
//   DONE    | Out_valid=1, result held until Out_ready
module nibble_serial_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   In_valid,
    output logic                   In_ready,
    input  logic [4*NIBBLES-1:0]   Op_A,
    input  logic [4*NIBBLES-1:0]   Op_B,
    input  logic                   Cin,
    input  logic                   Sub,
    output logic [3:0]             Add_A,
    output logic [3:0]             Add_B,
    output logic                   Add_Cin,
    input  logic [3:0]             Add_S,
    input  logic                   Add_Cout,
    output logic                   Out_valid,
    input  logic                   Out_ready,
    output logic [4*NIBBLES-1:0]   Sum,
    output logic                   Cout,
    output logic                   Ovf
);

    localparam int W  = 4 * NIBBLES;
    // The nibble index needs at least one bit, even when there is only one nibble.
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  beff_q;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic          add_cin;
    logic          last_nib;

    assign last_nib = (k_q == KW'(NIBBLES - 1));

    // Select nibble k of the latched operands for the adder; drive zeros outside RUN.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_q == ST_RUN) begin
            add_cin = carry_q;
            for (int i = 0; i < NIBBLES; i++) begin
                if (k_q == KW'(i)) begin
                    add_a = a_q[i*4 +: 4];
                    add_b = beff_q[i*4 +: 4];
                end
            end
        end
    end

    // Sequencing state: operand latch on accept, carry and nibble index during RUN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            beff_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (In_valid) begin
                        a_q     <= Op_A;
                        // Subtraction is A + ~B + 1; the forced carry-in supplies the +1.
                        beff_q  <= Sub ? ~Op_B : Op_B;
                        carry_q <= Sub ? 1'b1 : Cin;
                        k_q     <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_q <= Add_Cout;
                    if (last_nib) begin
                        k_q     <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (Out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Collect sum nibbles; final carry and signed overflow come from the top nibble.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == ST_RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (k_q == KW'(i)) begin
                    sum_q[i*4 +: 4] <= Add_S;
                end
            end
            if (last_nib) begin
                cout_q <= Add_Cout;
                ovf_q  <= (a_q[W-1] == beff_q[W-1]) && (Add_S[3] != a_q[W-1]);
            end
        end
    end

    assign In_ready  = (state_q == ST_IDLE);
    assign Out_valid = (state_q == ST_DONE);
    assign Add_A     = add_a;
    assign Add_B     = add_b;
    assign Add_Cin   = add_cin;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule
